// File: rtl/signed_bcd_conv_if.sv
// rtl/signed_bcd_conv_if.sv - sign type and handshake/result interface for the signed BCD converter
package signed_bcd_pkg;
    // Sign indicator: TEN lights the minus segment, OFF blanks it.
    typedef enum logic {
        OFF = 1'b0,
        TEN = 1'b1
    } sgmnt_e;
endpackage

interface signed_bcd_conv_if #(
    parameter int DW = 8,
    parameter int ND = 3
);
    import signed_bcd_pkg::*;

    logic            i_start;
    logic [DW-1:0]   i_data;
    logic            o_busy;
    logic            o_done;
    logic [4*ND-1:0] o_bcd;
    sgmnt_e          o_sign;
    logic            o_ovf;

    modport master (
        output i_start, i_data,
        input  o_busy, o_done, o_bcd, o_sign, o_ovf
    );

    modport slave (
        input  i_start, i_data,
        output o_busy, o_done, o_bcd, o_sign, o_ovf
    );
endinterface

// File: rtl/signed_bcd_conv.sv
// rtl/signed_bcd_conv.sv - signed two's-complement to sign + BCD magnitude converter (double dabble)
module signed_bcd_conv
    import signed_bcd_pkg::*;
#(
    parameter int DW = 8,
    parameter int ND = 3
) (
    input logic              i_clk,
    input logic              i_rst,
    signed_bcd_conv_if.slave bus
);
    localparam int CW = $clog2(DW + 1);
    localparam int BW = 4 * ND;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_e;

    state_e          r_state;
    logic [CW-1:0]   r_cnt;
    logic [DW-1:0]   r_mag;
    logic [BW-1:0]   r_work;
    logic            r_ovf_acc;
    logic            r_neg;
    logic            r_busy;
    logic            r_done;
    logic [BW-1:0]   r_bcd;
    sgmnt_e          r_sign;
    logic            r_ovf;

    logic [DW-1:0]   w_mag_in;
    logic [BW-1:0]   w_adj;
    logic [BW-1:0]   w_next_work;
    logic [DW-1:0]   w_next_mag;
    logic            w_top;

    // Negation in DW bits: the most-negative value maps onto 2^(DW-1), which
    // still fits because the magnitude is treated as unsigned.
    assign w_mag_in = bus.i_data[DW-1] ? ((~bus.i_data) + DW'(1)) : bus.i_data;

    // Add-3 correction on every digit that would reach 10 or more after doubling.
    always_comb begin
        w_adj = r_work;
        for (int d = 0; d < ND; d++) begin
            if (r_work[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = r_work[4*d +: 4] + 4'd3;
            end
        end
    end

    // One-bit shift of {bcd, magnitude}; the bit leaving the top digit is a
    // carry into a digit we do not keep, so it marks overflow.
    assign w_top       = w_adj[BW-1];
    assign w_next_work = {w_adj[BW-2:0], r_mag[DW-1]};
    assign w_next_mag  = {r_mag[DW-2:0], 1'b0};

    // Control FSM with registered status and result outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_mag     <= '0;
            r_work    <= '0;
            r_ovf_acc <= 1'b0;
            r_neg     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bcd     <= '0;
            r_sign    <= OFF;
            r_ovf     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (bus.i_start) begin
                        r_state   <= CONV;
                        r_busy    <= 1'b1;
                        r_mag     <= w_mag_in;
                        r_neg     <= bus.i_data[DW-1];
                        r_work    <= '0;
                        r_ovf_acc <= 1'b0;
                        r_cnt     <= '0;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                CONV: begin
                    r_mag     <= w_next_mag;
                    r_work    <= w_next_work;
                    r_ovf_acc <= r_ovf_acc | w_top;
                    if (r_cnt == CW'(DW - 1)) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_cnt   <= '0;
                        r_bcd   <= w_next_work;
                        r_ovf   <= r_ovf_acc | w_top;
                        r_sign  <= r_neg ? TEN : OFF;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_busy = r_busy;
    assign bus.o_done = r_done;
    assign bus.o_bcd  = r_bcd;
    assign bus.o_sign = r_sign;
    assign bus.o_ovf  = r_ovf;
endmodule

// File: tb/tb_signed_bcd_conv.sv
// tb/tb_signed_bcd_conv.sv - directed self-checking bench for signed_bcd_conv
module tb_signed_bcd_conv;
    import signed_bcd_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    signed_bcd_conv_if #(.DW(8), .ND(3)) b3 ();
    signed_bcd_conv_if #(.DW(8), .ND(2)) b2 ();

    signed_bcd_conv #(.DW(8), .ND(3)) dut3 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (b3.slave)
    );

    signed_bcd_conv #(.DW(8), .ND(2)) dut2 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (b2.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts one conversion on the ND=3 unit and reports the result and the
    // number of edges after the accepting edge until o_done was seen.
    task automatic run3(input logic [7:0] data, output logic [11:0] bcd,
                        output sgmnt_e sign, output logic ovf, output int lat);
        b3.i_data  = data;
        b3.i_start = 1'b1;
        step();
        b3.i_start = 1'b0;
        lat = 0;
        while (b3.o_done !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        bcd  = b3.o_bcd;
        sign = b3.o_sign;
        ovf  = b3.o_ovf;
        step();
    endtask

    task automatic run2(input logic [7:0] data, output logic [7:0] bcd,
                        output sgmnt_e sign, output logic ovf, output int lat);
        b2.i_data  = data;
        b2.i_start = 1'b1;
        step();
        b2.i_start = 1'b0;
        lat = 0;
        while (b2.o_done !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        bcd  = b2.o_bcd;
        sign = b2.o_sign;
        ovf  = b2.o_ovf;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_checks++;
        if ({b3.o_busy, b3.o_done, b3.o_ovf} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags3: busy/done/ovf=%b required 000", {b3.o_busy, b3.o_done, b3.o_ovf});
        end
        n_checks++;
        if (b3.o_bcd !== 12'h000 || b3.o_sign !== OFF) begin
            n_fail++;
            $display("FAIL reset_result3: bcd=%h sign=%0d required 000/OFF", b3.o_bcd, b3.o_sign);
        end
        n_checks++;
        if ({b2.o_busy, b2.o_done, b2.o_ovf} !== 3'b000 || b2.o_bcd !== 8'h00 || b2.o_sign !== OFF) begin
            n_fail++;
            $display("FAIL reset_nd2: busy=%b done=%b ovf=%b bcd=%h sign=%0d required all zero/OFF",
                     b2.o_busy, b2.o_done, b2.o_ovf, b2.o_bcd, b2.o_sign);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [11:0] bcd;
        sgmnt_e      sign;
        logic        ovf;
        int          lat;
        run3(8'h85, bcd, sign, ovf, lat);
        // o_done appears DW edges after the accepting edge, i.e. the 9th edge counting it.
        n_checks++;
        if (lat !== 8) begin
            n_fail++;
            $display("FAIL basic_latency: edges after accept=%0d required 8", lat);
        end
        n_checks++;
        if (bcd !== 12'h123 || sign !== TEN || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_0x85: bcd=%h sign=%0d ovf=%b required 123/TEN/0", bcd, sign, ovf);
        end
    endtask

    task automatic test_table();
        logic [7:0]  din  [4] = '{8'h80, 8'h7F, 8'h00, 8'hFF};
        logic [11:0] ebcd [4] = '{12'h128, 12'h127, 12'h000, 12'h001};
        sgmnt_e      esgn [4] = '{TEN, OFF, OFF, TEN};
        logic [11:0] bcd;
        sgmnt_e      sign;
        logic        ovf;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            run3(din[i], bcd, sign, ovf, lat);
            n_checks++;
            if (bcd !== ebcd[i] || sign !== esgn[i] || ovf !== 1'b0 || lat !== 8) begin
                n_fail++;
                $display("FAIL table_%h: bcd=%h sign=%0d ovf=%b lat=%0d required %h/%0d/0/8",
                         din[i], bcd, sign, ovf, lat, ebcd[i], esgn[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] din  [4] = '{8'h64, 8'h9C, 8'h63, 8'h9D};
        logic [7:0] ebcd [4] = '{8'h00, 8'h00, 8'h99, 8'h99};
        sgmnt_e     esgn [4] = '{OFF, TEN, OFF, TEN};
        logic       eovf [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [7:0] bcd;
        sgmnt_e     sign;
        logic       ovf;
        int         lat;
        for (int i = 0; i < 4; i++) begin
            run2(din[i], bcd, sign, ovf, lat);
            n_checks++;
            if (bcd !== ebcd[i] || sign !== esgn[i] || ovf !== eovf[i] || lat !== 8) begin
                n_fail++;
                $display("FAIL ovf_nd2_%h: bcd=%h sign=%0d ovf=%b lat=%0d required %h/%0d/%b/8",
                         din[i], bcd, sign, ovf, lat, ebcd[i], esgn[i], eovf[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int          done_cyc [2];
        logic [11:0] bcd_seen [2];
        sgmnt_e      sgn_seen [2];
        int          ndone = 0;
        int          busy_bad = 0;
        b3.i_data  = 8'h05;
        b3.i_start = 1'b1;
        step();
        b3.i_data  = 8'hFB;
        for (int c = 1; c <= 30 && ndone < 2; c++) begin
            step();
            if (b3.o_busy !== ~b3.o_done) busy_bad++;
            if (b3.o_done === 1'b1) begin
                done_cyc[ndone] = c;
                bcd_seen[ndone] = b3.o_bcd;
                sgn_seen[ndone] = b3.o_sign;
                ndone++;
            end
        end
        b3.i_start = 1'b0;
        step();
        step();
        n_checks++;
        if (ndone !== 2) begin
            n_fail++;
            $display("FAIL b2b_count: done pulses=%0d required 2", ndone);
        end else begin
            n_checks++;
            if (done_cyc[0] !== 8 || done_cyc[1] - done_cyc[0] !== 9) begin
                n_fail++;
                $display("FAIL b2b_spacing: first=%0d gap=%0d required 8/9", done_cyc[0], done_cyc[1] - done_cyc[0]);
            end
            n_checks++;
            if (bcd_seen[0] !== 12'h005 || sgn_seen[0] !== OFF) begin
                n_fail++;
                $display("FAIL b2b_first: bcd=%h sign=%0d required 005/OFF", bcd_seen[0], sgn_seen[0]);
            end
            n_checks++;
            if (bcd_seen[1] !== 12'h005 || sgn_seen[1] !== TEN) begin
                n_fail++;
                $display("FAIL b2b_second: bcd=%h sign=%0d required 005/TEN", bcd_seen[1], sgn_seen[1]);
            end
        end
        n_checks++;
        if (busy_bad !== 0) begin
            n_fail++;
            $display("FAIL b2b_busy: cycles with busy==done=%0d required 0", busy_bad);
        end
    endtask

    task automatic test_reset_abort();
        int          spurious = 0;
        logic [11:0] bcd;
        sgmnt_e      sign;
        logic        ovf;
        int          lat;
        b3.i_data  = 8'h85;
        b3.i_start = 1'b1;
        step();
        b3.i_start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (b3.o_busy !== 1'b0 || b3.o_done !== 1'b0 || b3.o_bcd !== 12'h000 ||
            b3.o_sign !== OFF || b3.o_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_outputs: busy=%b done=%b bcd=%h sign=%0d ovf=%b required 0/0/000/OFF/0",
                     b3.o_busy, b3.o_done, b3.o_bcd, b3.o_sign, b3.o_ovf);
        end
        for (int i = 0; i < 12; i++) begin
            step();
            if (b3.o_done === 1'b1 || b3.o_busy === 1'b1) spurious++;
        end
        n_checks++;
        if (spurious !== 0) begin
            n_fail++;
            $display("FAIL abort_no_done: active cycles=%0d required 0", spurious);
        end
        run3(8'h0A, bcd, sign, ovf, lat);
        n_checks++;
        if (bcd !== 12'h010 || sign !== OFF || ovf !== 1'b0 || lat !== 8) begin
            n_fail++;
            $display("FAIL abort_restart: bcd=%h sign=%0d ovf=%b lat=%0d required 010/OFF/0/8", bcd, sign, ovf, lat);
        end
    endtask

    task automatic test_ignore_start();
        int          ndone = 0;
        logic [11:0] bcd = 12'h000;
        sgmnt_e      sign = OFF;
        b3.i_data  = 8'h85;
        b3.i_start = 1'b1;
        step();
        b3.i_start = 1'b0;
        step();
        step();
        step();
        b3.i_data  = 8'h01;
        b3.i_start = 1'b1;
        step();
        b3.i_start = 1'b0;
        b3.i_data  = 8'hFF;
        for (int i = 0; i < 20; i++) begin
            step();
            if (b3.o_done === 1'b1) begin
                if (ndone == 0) begin
                    bcd  = b3.o_bcd;
                    sign = b3.o_sign;
                end
                ndone++;
            end
        end
        n_checks++;
        if (ndone !== 1) begin
            n_fail++;
            $display("FAIL ignore_count: done pulses=%0d required 1", ndone);
        end
        n_checks++;
        if (bcd !== 12'h123 || sign !== TEN) begin
            n_fail++;
            $display("FAIL ignore_result: bcd=%h sign=%0d required 123/TEN", bcd, sign);
        end
    endtask

    initial begin
        b3.i_start = 1'b0;
        b3.i_data  = 8'h00;
        b2.i_start = 1'b0;
        b2.i_data  = 8'h00;
        test_reset();
        test_basic();
        test_table();
        test_overflow();
        test_back_to_back();
        test_reset_abort();
        test_ignore_start();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
